// File: rtl/dncnt_sched.sv
// dncnt_sched: scheduler for an N-bit down counter with a programmable
// prescaler, pause/resume, stop and optional auto-reload.
// q, step and done are registered; busy and state come straight from
// the state register.
module dncnt_sched #(
    parameter int N  = 4,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          auto_reload,
    input  logic [N-1:0]  load_val,
    input  logic [PW-1:0] prescale,
    output logic [N-1:0]  q,
    output logic          step,
    output logic          done,
    output logic          busy,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [N-1:0]  Q_ONE  = N'(1);
    localparam logic [PW-1:0] PC_ONE = PW'(1);

    state_t        st, st_nxt;
    logic [N-1:0]  q_nxt;
    logic [PW-1:0] pc, pc_nxt;
    logic          step_nxt, done_nxt;

    // State register plus registered count and strobes.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create ordering-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            q    <= '0;
            pc   <= '0;
            step <= 1'b0;
            done <= 1'b0;
        end else begin
            st   <= st_nxt;
            q    <= q_nxt;
            pc   <= pc_nxt;
            step <= step_nxt;
            done <= done_nxt;
        end
    end

    // Next-state, count and strobe logic; priority stop > start > pause > step.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        st_nxt   = st;
        q_nxt    = q;
        pc_nxt   = pc;
        step_nxt = 1'b0;
        done_nxt = 1'b0;

        if (stop) begin
            // Abort: cancels any step due this cycle, no done pulse.
            st_nxt = IDLE;
            q_nxt  = '0;
            pc_nxt = '0;
        end else if (start) begin
            // Start or restart from any state; a zero load terminates at once.
            pc_nxt = '0;
            if (load_val == '0) begin
                q_nxt    = '0;
                done_nxt = 1'b1;
                st_nxt   = auto_reload ? RUN : DONE;
            end else begin
                q_nxt  = load_val;
                st_nxt = RUN;
            end
        end else begin
            unique case (st)
                RUN: begin
                    if (pause) begin
                        st_nxt = PAUSE;
                    end else if (pc == prescale) begin
                        pc_nxt   = '0;
                        step_nxt = 1'b1;
                        if (q > Q_ONE) begin
                            q_nxt = q - Q_ONE;
                        end else begin
                            // Terminal count (q==1, or q==0 under auto-reload
                            // with a zero load value).
                            done_nxt = 1'b1;
                            if (auto_reload) begin
                                q_nxt = load_val;
                            end else begin
                                q_nxt  = '0;
                                st_nxt = DONE;
                            end
                        end
                    end else begin
                        // Lowering prescale below pc lets pc wrap naturally.
                        pc_nxt = pc + PC_ONE;
                    end
                end
                PAUSE: begin
                    // pc is held, so the count resumes where it stopped.
                    if (!pause) st_nxt = RUN;
                end
                default: begin
                    // IDLE and DONE wait for start.
                end
            endcase
        end
    end

    assign busy  = (st == RUN) || (st == PAUSE);
    assign state = st;

endmodule

// File: tb/tb_dncnt_sched.sv
// tb_dncnt_sched: directed test-plan scenarios followed by randomized
// stimulus, every cycle compared with a behavioural reference model.
module tb_dncnt_sched;

    localparam int N  = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
    logic [N-1:0]  load_val = '0;
    logic [PW-1:0] prescale = '0;
    logic [N-1:0]  q;
    logic          step, done, busy;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: integer count, prescale phase and mode number
    // (0 idle, 1 running, 2 paused, 3 finished).
    int m_mode = 0, m_cnt = 0, m_phase = 0, m_step = 0, m_done = 0;

    dncnt_sched #(.N(N), .PW(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .load_val(load_val), .prescale(prescale),
        .q(q), .step(step), .done(done), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the spec rules for one clock edge to the model.
    task automatic model_edge();
        m_step = 0;
        m_done = 0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_phase = 0;
        end else if (stop) begin
            m_mode = 0; m_cnt = 0; m_phase = 0;
        end else if (start) begin
            m_phase = 0;
            m_cnt   = int'(load_val);
            if (m_cnt == 0) begin
                m_done = 1;
                m_mode = auto_reload ? 1 : 3;
            end else begin
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (pause) begin
                m_mode = 2;
            end else if (m_phase == int'(prescale)) begin
                m_phase = 0;
                m_step  = 1;
                if (m_cnt >= 2) begin
                    m_cnt = m_cnt - 1;
                end else begin
                    m_done = 1;
                    if (auto_reload) m_cnt = int'(load_val);
                    else begin m_cnt = 0; m_mode = 3; end
                end
            end else begin
                m_phase = (m_phase + 1) % (1 << PW);
            end
        end else if (m_mode == 2 && !pause) begin
            m_mode = 1;
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q",     32'(q),     32'(m_cnt));
        check("state", 32'(state), 32'(m_mode));
        check("busy",  32'(busy),  32'(m_mode == 1 || m_mode == 2));
        check("step",  32'(step),  32'(m_step));
        check("done",  32'(done),  32'(m_done));
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; stop = 0; pause = 0;
    endtask

    initial begin
        int seq1[6]  = '{5, 4, 3, 2, 1, 0};
        int seq2[10] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
        int n_step, n_done;

        // Reset for two cycles.
        rst = 1;
        tick(); tick();
        check("rst_q", 32'(q), 0);
        check("rst_state", 32'(state), 0);

        // S1: load 5, prescale 0, no reload.
        idle_inputs(); load_val = 5; prescale = 0; auto_reload = 0; start = 1;
        tick();
        start = 0;
        n_step = 0; n_done = 0;
        check("s1_q0", 32'(q), 32'(seq1[0]));
        for (int i = 1; i < 6; i++) begin
            tick();
            check("s1_seq", 32'(q), 32'(seq1[i]));
            n_step += int'(step); n_done += int'(done);
        end
        tick(); tick();
        n_step += int'(step); n_done += int'(done);
        check("s1_steps", 32'(n_step), 5);
        check("s1_dones", 32'(n_done), 1);
        check("s1_state", 32'(state), 3);
        check("s1_busy", 32'(busy), 0);

        // S2: load 3, prescale 2.
        load_val = 3; prescale = 2; start = 1;
        tick();
        start = 0;
        n_done = 0;
        check("s2_q0", 32'(q), 32'(seq2[0]));
        for (int i = 1; i < 10; i++) begin
            tick();
            check("s2_seq", 32'(q), 32'(seq2[i]));
            n_done += int'(done);
        end
        tick();
        n_done += int'(done);
        check("s2_dones", 32'(n_done), 1);

        // S3: auto-reload, load 2, prescale 0; then load 4 mid-run.
        load_val = 2; prescale = 0; auto_reload = 1; start = 1;
        tick();
        start = 0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_done += int'(done);
        end
        check("s3_dones", 32'(n_done), 5);
        check("s3_state", 32'(state), 1);
        load_val = 4;
        for (int i = 0; i < 12; i++) tick();
        stop = 1; tick(); stop = 0; auto_reload = 0;

        // S4: load 9, prescale 1, pause at q=6 for 7 cycles.
        load_val = 9; prescale = 1; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 40 && q != 6; i++) tick();
        check("s4_reach6", 32'(q), 6);
        pause = 1;
        for (int i = 0; i < 7; i++) tick();
        check("s4_frozen_q", 32'(q), 6);
        check("s4_pstate", 32'(state), 2);
        check("s4_pbusy", 32'(busy), 1);
        pause = 0;
        for (int i = 0; i < 20; i++) tick();

        // S5: stop at q=3, then start+stop together.
        load_val = 5; prescale = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && q != 3; i++) tick();
        check("s5_reach3", 32'(q), 3);
        stop = 1;
        tick();
        check("s5_stop_state", 32'(state), 0);
        check("s5_stop_q", 32'(q), 0);
        check("s5_stop_done", 32'(done), 0);
        start = 1;
        tick();
        check("s5_stopwins", 32'(state), 0);
        idle_inputs();
        tick();

        // S6: zero load, then reset mid-run at q=4.
        load_val = 0; start = 1;
        tick();
        start = 0;
        check("s6_done", 32'(done), 1);
        check("s6_state", 32'(state), 3);
        check("s6_q", 32'(q), 0);
        load_val = 8; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 20 && q != 4; i++) tick();
        check("s6_reach4", 32'(q), 4);
        rst = 1; start = 1;
        tick();
        check("s6_rst_q", 32'(q), 0);
        check("s6_rst_state", 32'(state), 0);
        check("s6_rst_busy", 32'(busy), 0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 47) == 0);
            start = ($urandom_range(0, 23) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
            if ($urandom_range(0, 7) == 0) load_val = N'($urandom);
            if ($urandom_range(0, 15) == 0)
                prescale = ($urandom_range(0, 7) == 0) ? PW'($urandom) : PW'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
